// File: rtl/wb_trap_pkg.sv
// Shared constants for the write-back trap unit:
// CSR addresses, SYSTEM decode fields, cause codes.
package wb_trap_pkg;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_RSVD  = 3'b100;

    localparam logic [11:0] IMM_ECALL  = 12'h000;
    localparam logic [11:0] IMM_EBREAK = 12'h001;
    localparam logic [11:0] IMM_MRET   = 12'h302;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MST_MIE  = 3;
    localparam int MST_MPIE = 7;

    localparam logic [4:0] EXC_IADDR_MIS = 5'd0;
    localparam logic [4:0] EXC_ILLEGAL   = 5'd2;
    localparam logic [4:0] EXC_BREAK     = 5'd3;
    localparam logic [4:0] EXC_LD_MIS    = 5'd4;
    localparam logic [4:0] EXC_ST_MIS    = 5'd6;
    localparam logic [4:0] EXC_ECALL_M   = 5'd11;

    localparam logic [4:0] IRQ_MSI    = 5'd3;
    localparam logic [4:0] IRQ_MTI    = 5'd7;
    localparam logic [4:0] IRQ_MEI    = 5'd11;
    localparam logic [4:0] IRQ_LOCAL0 = 5'd16;

    typedef struct packed {
        logic       irq;
        logic [4:0] code;
    } cause_t;

endpackage

// File: rtl/wb_trap_prio.sv
// Fixed-priority trap selector: request 0 wins,
// returns the cause tagged on the winning request.
module wb_trap_prio
    import wb_trap_pkg::*;
#(
    parameter int N = 4
) (
    input  logic   [N-1:0] req_i,
    input  cause_t [N-1:0] code_i,
    output logic           valid_o,
    output cause_t         cause_o
);

    // scan from lowest priority so the lowest index lands last
    always_comb begin
        valid_o = 1'b0;
        cause_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                cause_o = code_i[i];
            end
        end
    end

endmodule

// File: rtl/wb_trap_unit.sv
// Write-back trap unit: M-mode CSR file, trap
// selection, MRET and redirect/commit generation.
module wb_trap_unit
    import wb_trap_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              instruction_i,
    input  logic [31:0]              mem_addr_i,
    input  logic                     e_illegal_inst_i,
    input  logic                     e_inst_addr_mis_i,
    input  logic                     e_ld_addr_mis_i,
    input  logic                     e_st_addr_mis_i,
    input  logic                     xint_meip_i,
    input  logic                     xint_mtip_i,
    input  logic                     xint_msip_i,
    input  logic [NUM_LOCAL_IRQ-1:0] local_irq_i,
    input  logic [31:0]              csr_wdata_i,
    output logic [31:0]              csr_rdata_o,
    output logic                     commit_o,
    output logic                     redirect_o,
    output logic [31:0]              redirect_pc_o,
    output logic                     trap_o
);

    localparam int NREQ = 9 + NUM_LOCAL_IRQ;
    localparam int XB   = 3 + NUM_LOCAL_IRQ;
    localparam logic [31:0] LIRQ_MASK =
        32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
    localparam logic [31:0] MIE_MASK = LIRQ_MASK | 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK =
        VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] MTVEC_RST = RESET_MTVEC & MTVEC_MASK;

    logic        st_mie, st_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q;
    logic [31:0] mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle_q, minstret_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  zimm;
    logic [11:0] csr_addr;
    logic        is_sys, csr_op, is_ecall, is_ebreak, is_mret;
    logic [31:0] mip_w, mstatus_w, rd_val, src, wr_val, tval;
    logic        addr_ok, ro, wr_req, csr_illegal, csr_we;
    logic        trap, mret_go, any_req, vec;
    logic [31:0] trap_pc;
    logic        unused_rd;

    logic   [NREQ-1:0] req;
    cause_t [NREQ-1:0] req_code;
    cause_t            sel;

    assign opcode    = instruction_i[6:0];
    assign funct3    = instruction_i[14:12];
    assign zimm      = instruction_i[19:15];
    assign csr_addr  = instruction_i[31:20];
    assign unused_rd = ^instruction_i[11:7];

    assign is_sys    = valid_i & (opcode == OPC_SYSTEM);
    assign csr_op    = is_sys & (funct3 != F3_PRIV);
    assign is_ecall  = is_sys & (funct3 == F3_PRIV) & (csr_addr == IMM_ECALL);
    assign is_ebreak = is_sys & (funct3 == F3_PRIV) & (csr_addr == IMM_EBREAK);
    assign is_mret   = is_sys & (funct3 == F3_PRIV) & (csr_addr == IMM_MRET);

    // live interrupt lines and mstatus view
    always_comb begin
        mip_w = '0;
        mip_w[11] = xint_meip_i;
        mip_w[7]  = xint_mtip_i;
        mip_w[3]  = xint_msip_i;
        mip_w[16 +: NUM_LOCAL_IRQ] = local_irq_i;
        mstatus_w = '0;
        mstatus_w[12:11]  = 2'b11;
        mstatus_w[MST_MPIE] = st_mpie;
        mstatus_w[MST_MIE]  = st_mie;
    end

    // CSR read mux with existence / read-only flags
    always_comb begin
        rd_val  = '0;
        addr_ok = 1'b1;
        ro      = 1'b0;
        unique case (csr_addr)
            CSR_MSTATUS:   rd_val = mstatus_w;
            CSR_MIE:       rd_val = mie_q;
            CSR_MTVEC:     rd_val = mtvec_q;
            CSR_MSCRATCH:  rd_val = mscratch_q;
            CSR_MEPC:      rd_val = mepc_q;
            CSR_MCAUSE:    rd_val = mcause_q;
            CSR_MTVAL:     rd_val = mtval_q;
            CSR_MIP:       begin rd_val = mip_w; ro = 1'b1; end
            CSR_MCYCLE:    rd_val = mcycle_q[31:0];
            CSR_MCYCLEH:   rd_val = mcycle_q[63:32];
            CSR_MINSTRET:  rd_val = minstret_q[31:0];
            CSR_MINSTRETH: rd_val = minstret_q[63:32];
            CSR_MHARTID:   ro = 1'b1;
            default:       addr_ok = 1'b0;
        endcase
    end

    assign src    = funct3[2] ? {27'b0, zimm} : csr_wdata_i;
    assign wr_req = csr_op & ((funct3[1:0] == 2'b01) | (zimm != 5'd0));
    assign csr_illegal = csr_op &
        (~addr_ok | (wr_req & ro) | (funct3 == F3_RSVD));

    // RW / set / clear result
    always_comb begin
        unique case (funct3[1:0])
            2'b01:   wr_val = src;
            2'b10:   wr_val = rd_val | src;
            2'b11:   wr_val = rd_val & ~src;
            default: wr_val = rd_val;
        endcase
    end

    // trap requests, index 0 = highest priority
    always_comb begin
        req      = '0;
        req_code = '0;
        req[0] = mip_w[11] & mie_q[11] & st_mie;
        req[1] = mip_w[3]  & mie_q[3]  & st_mie;
        req[2] = mip_w[7]  & mie_q[7]  & st_mie;
        req_code[0] = cause_t'{irq: 1'b1, code: IRQ_MEI};
        req_code[1] = cause_t'{irq: 1'b1, code: IRQ_MSI};
        req_code[2] = cause_t'{irq: 1'b1, code: IRQ_MTI};
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            req[3+i] = mip_w[16+i] & mie_q[16+i] & st_mie;
            req_code[3+i] =
                cause_t'{irq: 1'b1, code: IRQ_LOCAL0 + 5'(i)};
        end
        req[XB]   = e_inst_addr_mis_i;
        req[XB+1] = e_illegal_inst_i | csr_illegal;
        req[XB+2] = is_ebreak;
        req[XB+3] = is_ecall;
        req[XB+4] = e_ld_addr_mis_i;
        req[XB+5] = e_st_addr_mis_i;
        req_code[XB]   = cause_t'{irq: 1'b0, code: EXC_IADDR_MIS};
        req_code[XB+1] = cause_t'{irq: 1'b0, code: EXC_ILLEGAL};
        req_code[XB+2] = cause_t'{irq: 1'b0, code: EXC_BREAK};
        req_code[XB+3] = cause_t'{irq: 1'b0, code: EXC_ECALL_M};
        req_code[XB+4] = cause_t'{irq: 1'b0, code: EXC_LD_MIS};
        req_code[XB+5] = cause_t'{irq: 1'b0, code: EXC_ST_MIS};
    end

    wb_trap_prio #(.N(NREQ)) u_prio (
        .req_i   (req),
        .code_i  (req_code),
        .valid_o (any_req),
        .cause_o (sel)
    );

    assign trap    = valid_i & any_req;
    assign mret_go = is_mret & ~trap;
    assign csr_we  = wr_req & addr_ok & ~ro & ~trap;
    assign vec     = VECTORED_EN & mtvec_q[0] & sel.irq;
    assign trap_pc = {mtvec_q[31:2], 2'b00} +
        (vec ? {25'b0, sel.code, 2'b00} : 32'h0);

    // mtval source for the selected cause
    always_comb begin
        tval = '0;
        if (!sel.irq) begin
            unique case (sel.code)
                EXC_IADDR_MIS,
                EXC_BREAK:   tval = pc_i;
                EXC_ILLEGAL: tval = instruction_i;
                EXC_LD_MIS,
                EXC_ST_MIS:  tval = mem_addr_i;
                default:     tval = '0;
            endcase
        end
    end

    assign trap_o      = ~rst_i & trap;
    assign redirect_o  = ~rst_i & (trap | mret_go);
    assign commit_o    = ~rst_i & valid_i & ~trap;
    assign csr_rdata_o = (~rst_i & csr_op) ? rd_val : 32'h0;
    assign redirect_pc_o = rst_i   ? 32'h0 :
                           trap    ? trap_pc :
                           mret_go ? mepc_q : 32'h0;

    // trap entry, MRET stacking and CSR writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap) begin
            mepc_q   <= {pc_i[31:2], 2'b00};
            mcause_q <= {sel.irq, 26'b0, sel.code};
            mtval_q  <= tval;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (mret_go) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_we) begin
            unique case (csr_addr)
                CSR_MSTATUS: begin
                    st_mie  <= wr_val[MST_MIE];
                    st_mpie <= wr_val[MST_MPIE];
                end
                CSR_MIE:      mie_q      <= wr_val & MIE_MASK;
                CSR_MTVEC:    mtvec_q    <= wr_val & MTVEC_MASK;
                CSR_MSCRATCH: mscratch_q <= wr_val;
                CSR_MEPC:     mepc_q     <= {wr_val[31:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= wr_val;
                CSR_MTVAL:    mtval_q    <= wr_val;
                default:      ;
            endcase
        end
    end

    // 64-bit counters; a half write replaces the increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && csr_addr == CSR_MCYCLE)
                mcycle_q <= {mcycle_q[63:32], wr_val};
            else if (csr_we && csr_addr == CSR_MCYCLEH)
                mcycle_q <= {wr_val, mcycle_q[31:0]};
            else
                mcycle_q <= mcycle_q + 64'd1;
            if (csr_we && csr_addr == CSR_MINSTRET)
                minstret_q <= {minstret_q[63:32], wr_val};
            else if (csr_we && csr_addr == CSR_MINSTRETH)
                minstret_q <= {wr_val, minstret_q[31:0]};
            else if (valid_i && !trap)
                minstret_q <= minstret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_trap_unit.sv
// Randomised + directed bench for wb_trap_unit
// against an architectural reference model.
module tb_wb_trap_unit;

    localparam logic [31:0] RST_TVEC = 32'h0000_0201;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] MRET     = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, instruction_i, mem_addr_i, csr_wdata_i;
    logic        e_illegal_inst_i, e_inst_addr_mis_i;
    logic        e_ld_addr_mis_i, e_st_addr_mis_i;
    logic        xint_meip_i, xint_mtip_i, xint_msip_i;
    logic [3:0]  local_irq_i;
    logic [31:0] csr_rdata_o, redirect_pc_o;
    logic        commit_o, redirect_o, trap_o;

    int total = 0;
    int bad   = 0;

    logic        m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cycle, m_instret;
    logic [31:0] last_rd, last_rpc;
    logic        last_trap, last_commit, last_redir;

    always #5 clk = ~clk;

    wb_trap_unit #(
        .NUM_LOCAL_IRQ (4),
        .VECTORED_EN   (1'b1),
        .RESET_MTVEC   (RST_TVEC)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .pc_i              (pc_i),
        .instruction_i     (instruction_i),
        .mem_addr_i        (mem_addr_i),
        .e_illegal_inst_i  (e_illegal_inst_i),
        .e_inst_addr_mis_i (e_inst_addr_mis_i),
        .e_ld_addr_mis_i   (e_ld_addr_mis_i),
        .e_st_addr_mis_i   (e_st_addr_mis_i),
        .xint_meip_i       (xint_meip_i),
        .xint_mtip_i       (xint_mtip_i),
        .xint_msip_i       (xint_msip_i),
        .local_irq_i       (local_irq_i),
        .csr_wdata_i       (csr_wdata_i),
        .csr_rdata_o       (csr_rdata_o),
        .commit_o          (commit_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .trap_o            (trap_o)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_ie = 0;
        m_tvec = RST_TVEC; m_scratch = 0; m_epc = 0;
        m_cause = 0; m_tval = 0; m_cycle = 0; m_instret = 0;
    endtask

    function automatic logic m_known(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340,
                         12'h341, 12'h342, 12'h343, 12'h344,
                         12'hB00, 12'hB02, 12'hB80, 12'hB82,
                         12'hF14};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a,
                                           input logic [31:0] mip);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7)
                                     | (32'(m_mie) << 3);
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return mip;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // one retirement slot: drive, predict, check, advance
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] ma,
                        input logic [31:0] wd, input logic [3:0] exc,
                        input logic [2:0] xi, input logic [3:0] li);
        int order [7] = '{11, 3, 7, 16, 17, 18, 19};
        int cause;
        logic irq, csrop, wr, ill, mret, ecall, ebrk;
        logic e_trap, e_commit, e_redir;
        logic [31:0] mip, old, src, nv, e_rd, e_rpc, tval;
        logic [63:0] ncyc, nins;
        logic [11:0] a;
        logic [2:0] f3;
        logic [4:0] zi;
        valid_i = v; pc_i = pc; instruction_i = ins;
        mem_addr_i = ma; csr_wdata_i = wd;
        e_illegal_inst_i = exc[0]; e_inst_addr_mis_i = exc[1];
        e_ld_addr_mis_i = exc[2]; e_st_addr_mis_i = exc[3];
        xint_meip_i = xi[2]; xint_mtip_i = xi[1];
        xint_msip_i = xi[0]; local_irq_i = li;
        #1;
        a = ins[31:20]; f3 = ins[14:12]; zi = ins[19:15];
        mip = {12'b0, li, 4'b0, xi[2], 3'b0, xi[1], 3'b0,
               xi[0], 3'b0};
        csrop = v && ins[6:0] == 7'h73 && f3 != 3'd0;
        mret  = v && ins[6:0] == 7'h73 && f3 == 0 && a == 12'h302;
        ecall = v && ins[6:0] == 7'h73 && f3 == 0 && a == 12'h000;
        ebrk  = v && ins[6:0] == 7'h73 && f3 == 0 && a == 12'h001;
        old = m_read(a, mip);
        wr  = csrop && (f3[1:0] == 2'b01 || zi != 0);
        ill = csrop && (!m_known(a) ||
              (wr && (a == 12'h344 || a == 12'hF14)));
        cause = -1; tval = 0;
        if (v && m_mie)
            foreach (order[i])
                if (cause < 0 && mip[order[i]] && m_ie[order[i]])
                    cause = order[i];
        irq = cause >= 0;
        if (v && cause < 0) begin
            if (exc[1])              begin cause = 0;  tval = pc;  end
            else if (exc[0] || ill)  begin cause = 2;  tval = ins; end
            else if (ebrk)           begin cause = 3;  tval = pc;  end
            else if (ecall)          begin cause = 11; tval = 0;   end
            else if (exc[2])         begin cause = 4;  tval = ma;  end
            else if (exc[3])         begin cause = 6;  tval = ma;  end
        end
        e_trap   = cause >= 0;
        e_commit = v && !e_trap;
        e_redir  = e_trap || mret;
        e_rd     = csrop ? old : 32'h0;
        if (e_trap)
            e_rpc = (m_tvec & ~32'h3) +
                    ((irq && m_tvec[0]) ? 32'(cause * 4) : 32'h0);
        else
            e_rpc = mret ? m_epc : 32'h0;
        chk("trap", trap_o, e_trap);
        chk("commit", commit_o, e_commit);
        chk("redirect", redirect_o, e_redir);
        chk("redirect_pc", redirect_pc_o, e_rpc);
        chk("rdata", csr_rdata_o, e_rd);
        last_rd = csr_rdata_o; last_rpc = redirect_pc_o;
        last_trap = trap_o; last_commit = commit_o;
        last_redir = redirect_o;
        src = f3[2] ? {27'b0, zi} : wd;
        nv = f3[1:0] == 2'b01 ? src :
             f3[1:0] == 2'b10 ? (old | src) : (old & ~src);
        ncyc = m_cycle + 1;
        nins = m_instret + 64'(e_commit);
        if (e_trap) begin
            m_epc = pc & ~32'h3;
            m_cause = {irq, 31'(cause)};
            m_tval = irq ? 32'h0 : tval;
            m_mpie = m_mie; m_mie = 0;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr) begin
            case (a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_ie = nv & 32'h000F_0888;
                12'h305: m_tvec = nv & 32'hFFFF_FFFD;
                12'h340: m_scratch = nv;
                12'h341: m_epc = nv & ~32'h3;
                12'h342: m_cause = nv;
                12'h343: m_tval = nv;
                12'hB00: ncyc = {m_cycle[63:32], nv};
                12'hB80: ncyc = {nv, m_cycle[31:0]};
                12'hB02: nins = {m_instret[63:32], nv};
                12'hB82: nins = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        m_cycle = ncyc; m_instret = nins;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] a,
                       input logic [4:0] rs, input logic [31:0] wd);
        step(1, 32'h200, {a, rs, f3, 5'd1, 7'h73}, 0, wd, 0, 0, 0);
    endtask

    task automatic rdc(input logic [11:0] a);
        csr(3'd2, a, 5'd0, 32'h0);
    endtask

    logic [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                12'h341, 12'h342, 12'h343, 12'h344,
                                12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                12'hF14, 12'h7C0};
    logic [2:0]  f3s   [6]  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    initial begin
        logic [31:0] ins, w;
        rst_i = 1;
        valid_i = 1; pc_i = 0; instruction_i = 32'h3050_2073;
        mem_addr_i = 0; csr_wdata_i = 0;
        e_illegal_inst_i = 0; e_inst_addr_mis_i = 0;
        e_ld_addr_mis_i = 0; e_st_addr_mis_i = 0;
        xint_meip_i = 1; xint_mtip_i = 0; xint_msip_i = 0;
        local_irq_i = 0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_commit", commit_o, 0);
        chk("rst_rdata", csr_rdata_o, 0);
        valid_i = 0; xint_meip_i = 0;
        rst_i = 0;

        rdc(12'h305);
        chk("rst_mtvec", last_rd, RST_TVEC);
        chk("csrrs_commit", last_commit, 1);
        rdc(12'hB02);
        chk("minstret_1", last_rd, 1);
        rdc(12'hB00);
        chk("mcycle_2", last_rd, 2);

        csr(3'd1, 12'h305, 5'd2, 32'h101);
        csr(3'd1, 12'h304, 5'd2, 32'h80);
        csr(3'd6, 12'h300, 5'd8, 32'h0);
        step(1, 32'h40, NOP, 0, 0, 0, 3'b010, 0);
        chk("mti_trap", last_trap, 1);
        chk("mti_vec_pc", last_rpc, 32'h11C);
        rdc(12'h342);
        chk("mti_cause", last_rd, 32'h8000_0007);
        rdc(12'h341);
        chk("mti_epc", last_rd, 32'h40);
        rdc(12'h300);
        chk("mti_status", last_rd, 32'h1880);

        step(1, 32'h120, MRET, 0, 0, 0, 0, 0);
        chk("mret_pc", last_rpc, 32'h40);
        chk("mret_commit", last_commit, 1);
        rdc(12'h300);
        chk("mret_status", last_rd, 32'h1888);

        csr(3'd1, 12'h304, 5'd2, 32'h1_0888);
        step(1, 32'h44, NOP, 0, 0, 0, 3'b110, 4'b0001);
        chk("mei_pc", last_rpc, 32'h12C);
        rdc(12'h342);
        chk("mei_cause", last_rd, 32'h8000_000B);

        ins = {12'hF14, 5'd2, 3'd1, 5'd1, 7'h73};
        step(1, 32'h60, ins, 32'h5, 32'h55, 4'b0100, 0, 0);
        chk("hart_commit", last_commit, 0);
        rdc(12'h342);
        chk("hart_cause", last_rd, 2);
        rdc(12'h343);
        chk("hart_tval", last_rd, ins);
        rdc(12'hF14);
        chk("hart_val", last_rd, 0);

        step(1, 32'h64, 32'h0000_2083, 32'h1003, 0, 4'b0100, 0, 0);
        rdc(12'h342);
        chk("ldmis_cause", last_rd, 4);
        rdc(12'h343);
        chk("ldmis_tval", last_rd, 32'h1003);
        step(1, 32'h68, ECALL, 0, 0, 0, 0, 0);
        rdc(12'h342);
        chk("ecall_cause", last_rd, 11);
        rdc(12'h343);
        chk("ecall_tval", last_rd, 0);
        step(1, 32'h6C, EBREAK, 0, 0, 0, 0, 0);
        rdc(12'h343);
        chk("ebreak_tval", last_rd, 32'h6C);

        csr(3'd1, 12'hB00, 5'd2, 32'hFFFF_FFFF);
        csr(3'd1, 12'hB80, 5'd2, 32'h0);
        rdc(12'hB00);
        chk("mcycle_lo_pre", last_rd, 32'hFFFF_FFFF);
        rdc(12'hB80);
        chk("mcycle_carry", last_rd, 1);

        for (int n = 0; n < 600; n++) begin
            int k;
            logic [4:0] rs;
            k = $urandom_range(0, 9);
            rs = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            if (k < 5)
                ins = {addrs[$urandom_range(0, 13)], rs,
                       f3s[$urandom_range(0, 5)], 5'd1, 7'h73};
            else if (k == 5) ins = ECALL;
            else if (k == 6) ins = EBREAK;
            else if (k == 7) ins = MRET;
            else ins = NOP;
            w = $urandom;
            step($urandom_range(0, 7) != 0, $urandom, ins, $urandom,
                 w,
                 {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0},
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0},
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
        end

        csr(3'd1, 12'h304, 5'd2, 32'h80);
        csr(3'd6, 12'h300, 5'd8, 32'h0);
        valid_i = 1; pc_i = 32'h80; instruction_i = NOP;
        xint_mtip_i = 1;
        #1;
        chk("pre_rst_trap", trap_o, 1);
        rst_i = 1;
        #1;
        chk("rst_trap", trap_o, 0);
        chk("rst_redirect", redirect_o, 0);
        chk("rst_commit2", commit_o, 0);
        chk("rst_rpc", redirect_pc_o, 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        valid_i = 0; xint_mtip_i = 0;
        rst_i = 0;
        rdc(12'h305);
        chk("rst2_mtvec", last_rd, RST_TVEC);
        rdc(12'h300);
        chk("rst2_status", last_rd, 32'h1800);
        rdc(12'h304);
        chk("rst2_mie", last_rd, 0);
        rdc(12'h342);
        chk("rst2_cause", last_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_trap_unit.md
Name: wb_trap_unit

Overview:
- Parametrised successor of the write-back exception/CSR logic.
- Sits at write-back. Owns the machine-mode CSR file, prioritises synchronous exceptions and enabled interrupts for the retiring instruction, and executes MRET.
- Emits a redirect PC, a flush, and a commit qualifier that gates the register-file write.
- Adds a configurable local-interrupt count, vectored mtvec, MIE/MPIE stacking, and 64-bit mcycle/minstret.

Parameters:
- NUM_LOCAL_IRQ, 4, local interrupt lines mapped to mcause 16..16+NUM_LOCAL_IRQ-1 (1..16)
- VECTORED_EN, 1, 1 = honour mtvec.MODE=1; 0 = MODE field hard-wired to 0
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec (MODE bits forced per VECTORED_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- valid_i  in  1  an instruction is retiring this cycle
- pc_i  in  32  PC of retiring instruction
- instruction_i  in  32  retiring instruction word
- mem_addr_i  in  32  load/store effective address
- e_illegal_inst_i, e_inst_addr_mis_i, e_ld_addr_mis_i, e_st_addr_mis_i  in  1 each  upstream exception flags
- xint_meip_i, xint_mtip_i, xint_msip_i  in  1 each  level-sensitive machine interrupts
- local_irq_i  in  NUM_LOCAL_IRQ  level-sensitive local interrupts
- csr_wdata_i  in  32  rs1 register value for CSR ops
- csr_rdata_o  out  32  old CSR value, written to rd
- commit_o  out  1  instruction commits (rf write allowed, minstret counts)
- redirect_o  out  1  fetch must redirect and flush younger stages
- redirect_pc_o  out  32  redirect target
- trap_o  out  1  trap taken this cycle

Behaviour:
- Decode from instruction_i: opcode [6:0], funct3 [14:12], rs1/zimm [19:15], csr address [31:20].
- CSR op = SYSTEM opcode with funct3 != 0. funct3 = 0 with [31:20] = 0 / 1 / 12'h302 decodes as ECALL / EBREAK / MRET.
- Implemented CSRs:
  - mstatus: MIE[3], MPIE[7], MPP[12:11] read-only 2'b11; other bits read 0.
  - mie: bits 3, 7, 11, 16+.
  - mip: read-only, reflects live inputs.
  - mtvec, mscratch, mepc (bits [1:0] read 0), mcause, mtval.
  - mcycle/mcycleh, minstret/minstreth: writable.
  - mhartid: read-only, 0.
- Any other CSR address, or a write to a read-only CSR, raises illegal instruction. "Write" means RW/RWI, or RS/RC/RSI/RCI with a nonzero rs1/zimm.
- CSR ops:
  - 001 RW, 010 RS, 011 RC use csr_wdata_i; 101/110/111 use zero-extended zimm.
  - RS/RC with zero source perform no write and are not illegal on read-only CSRs.
- All decisions are combinational within the valid_i cycle; all CSR state updates on the next rising edge. csr_rdata_o is combinational, pre-update value.
- Interrupt pending = mip & mie & {MIE}. It is taken only when valid_i = 1, before the instruction, so the instruction does not commit.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > local, lowest index first.
- Interrupts beat exceptions.
- Exception priority and mtval:
  - inst_addr_mis(0): mtval = pc_i
  - illegal(2): mtval = instruction_i; includes CSR-generated illegal
  - EBREAK(3): mtval = pc_i
  - ECALL(11): mtval = 0
  - ld_mis(4): mtval = mem_addr_i
  - st_mis(6): mtval = mem_addr_i
- Interrupts write mtval = 0. mcause[31] = 1 for interrupts.
- On trap:
  - trap_o = redirect_o = 1; commit_o = 0.
  - mepc <= {pc_i[31:2], 2'b00}; mcause and mtval written.
  - MPIE <= MIE; MIE <= 0.
  - redirect_pc_o = {mtvec[31:2], 2'b00}, plus 4*cause when an interrupt is taken with MODE = 1.
  - Any CSR write in that cycle is suppressed.
- MRET without exception:
  - redirect_o = 1, redirect_pc_o = mepc, commit_o = 1.
  - MIE <= MPIE; MPIE <= 1.
- commit_o = valid_i & ~trap_o. The pipeline ANDs it with its own rd-write decode.
- mcycle increments every cycle.
- minstret increments when commit_o = 1.
- A CSR write to a counter half overrides that cycle's increment of the whole 64-bit counter. Carry propagates low to high; wraps at 2^64.
- valid_i = 0: no trap, no CSR write; redirect_o = 0, trap_o = 0, commit_o = 0.
- Reset (asynchronous, any cycle including mid-trap):
  - All CSRs cleared except mtvec = RESET_MTVEC and MPP = 2'b11.
  - Counters 0.
  - All outputs 0 while rst_i is high.

Decomposition:
- Package wb_trap_pkg holds:
  - CSR address constants and opcode/funct3/SYSTEM immediates.
  - mcause codes and mstatus bit indices.
- One sub-module, wb_trap_prio: parametrised fixed-priority encoder over {exceptions, interrupts} producing cause and valid. Everything else stays flat.

Test Plan:
- After reset, csrrs x1, mtvec, x0 -> csr_rdata_o = RESET_MTVEC, no write, commit_o = 1. mcycle increments each cycle; minstret = 1 after commit.
- Set MIE = 1, mie.MTIE = 1, mtvec = 32'h100|1, raise xint_mtip_i at pc 32'h40 -> trap_o = 1, redirect_pc_o = 32'h11C, mcause = 32'h8000_0007, mepc = 32'h40, MIE = 0, MPIE = 1.
- Then MRET -> redirect_pc_o = 32'h40, MIE = 1, MPIE = 1. Simultaneous meip+mtip+local_irq[0] -> cause 11 selected.
- csrrw to mhartid with e_ld_addr_mis_i = 1 -> illegal wins: mcause = 2, mtval = instruction_i, mhartid unchanged, commit_o = 0.
- Load misaligned at mem_addr_i = 32'h1003 -> mcause = 4, mtval = 32'h1003. ECALL -> mcause = 11, mtval = 0.
- Write mcycle = 32'hFFFF_FFFF, mcycleh = 0 -> next cycle mcycleh = 1, mcycle = 0. Assert rst_i mid-trap -> all CSRs and outputs at reset values immediately.
